mult_job_dispatcher: RTL and testbench
======================================

// Module: mult_job_dispatcher
// PURPOSE
//  Upstream/downstream wrapper for the sequential shift-add multiplier: buffers operand
//  pairs in a FIFO, drives the multiplier's start/ready handshake one job at a time, and
//  captures each 2W-bit product into a valid/ready output register. Results leave in issue order.
// PARAMETERS
//  W      8   operand width; the product is 2*W bits
//  DEPTH  4   operand FIFO entries; power of two, >= 2
//  ACC_W  24  accumulator width; used only with MJD_ACCUMULATE_EN
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous active-high reset
//  in_valid      in   1      operand pair offered
//  in_ready      out  1      FIFO can accept (= !full)
//  in_a, in_b    in   W      operands
//  mult_start    out  1      start pulse to multiplier control
//  mult_a/mult_b out  W      operands to multiplier datapath; held stable for the whole job
//  mult_ready    in   1      multiplier idle flag (1 = idle/done)
//  mult_product  in   2W     multiplier result; valid while mult_ready=1 after a job
//  out_valid     out  1      product available
//  out_ready     in   1      consumer accepts
//  out_product   out  2W     captured product
//  busy          out  1      1 when state != IDLE or FIFO is non-empty
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE; mult_start, mult_a, mult_b, out_valid, out_product and busy = 0.
//   in_ready = 1 in the first cycle after reset.
//  FIFO: push on in_valid&&in_ready. in_ready is derived from the registered count; there is
//   no same-cycle bypass when full. Pointers wrap modulo DEPTH.
//  FSM:
//   IDLE:      if FIFO non-empty && mult_ready: pop head into mult_a/mult_b -> START
//   START:     mult_start=1 for exactly this cycle -> WAIT_LOW
//   WAIT_LOW:  stay until mult_ready==0 -> WAIT_HIGH (the multiplier holds in Init while
//              start is high, so start must never exceed 1 cycle)
//   WAIT_HIGH: on mult_ready==1, latch mult_product into out_product, set out_valid -> DRAIN
//   DRAIN:     on out_valid&&out_ready, clear out_valid -> IDLE
//  Only one job is in flight. The next job pops no earlier than the IDLE cycle after the drain.
//  out_product and out_valid hold constant while out_valid && !out_ready.
//  mult_a/mult_b change only on a pop.
//  Push and pop in the same cycle: count unchanged; legal when full (the popped slot does not
//   re-enable in_ready until the next cycle).
//  Arithmetic: out_product = mult_product unmodified (unsigned, 2W bits). No truncation.
//  Reset mid-job (any state) returns to the reset values in the next cycle. In-flight and
//   buffered jobs are discarded. The multiplier shares rst and is reset with this block.
//  Pop latency: job at FIFO head with mult_ready=1 -> mult_start 1 cycle after the pop cycle.
// CONFIGURATION
//  MJD_ACCUMULATE_EN defined: adds input acc_clr (1) and output acc_sum (ACC_W).
//   acc_sum resets to 0. On each out_valid&&out_ready, acc_sum += zero-extended
//   out_product (mod 2^ACC_W). acc_clr clears acc_sum. When acc_clr and a delivery occur
//   in the same cycle, acc_sum <= that delivered product.
//  MJD_ACCUMULATE_EN undefined: acc_clr and acc_sum ports and all accumulator logic are absent.
//   Dispatcher behaviour is otherwise identical.
// TESTING  (bench pairs the block with the multiplier CU+datapath, or a model of ready
//   falling 1 cycle after start and rising after the job)
//  1. Apply rst 2 cycles -> out_valid=0, mult_start=0, busy=0, in_ready=1, out_product=0.
//  2. Push a=3,b=5 with out_ready=0 -> single-cycle mult_start. After ready rises,
//     out_product=15 and out_valid=1, held stable 5 cycles. Assert out_ready -> IDLE.
//  3. Push a=255,b=255 -> out_product=16'hFE01. Push a=0,b=200 -> out_product=0.
//  4. Hold out_ready=0 and push continuously -> exactly DEPTH+1=5 pairs accepted, then
//     in_ready=0. Release out_ready -> the 5 products emerge in push order.
//  5. Assert rst while in WAIT_HIGH -> next cycle: out_valid=0, FIFO empty, busy=0.
//     No stale product appears afterwards.
//  6. MJD_ACCUMULATE_EN: deliver 15 then 16'hFE01 -> acc_sum=24'h00FE10. Assert acc_clr
//     together with delivery of 7 -> acc_sum=7.

Source files
------------

// File: rtl/mult_job_dispatcher.sv
// mult_job_dispatcher
// Feeds a sequential shift-add multiplier one job at a time. Operand pairs queue up in a
// small FIFO. A five-state controller pops the head, pulses mult_start for one cycle, and
// waits for the multiplier's ready flag to fall and then rise. It then captures the 2W-bit
// product into a valid/ready output register. Products leave in the order the operands
// were accepted.
// Optional feature: define MJD_ACCUMULATE_EN to add acc_clr/acc_sum, a running sum of
// every delivered product (modulo 2^ACC_W).
// Output handshake: a product transfers on any rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_valid and out_product are frozen.
module mult_job_dispatcher #(
    parameter int W     = 8,
    parameter int DEPTH = 4
`ifdef MJD_ACCUMULATE_EN
    ,
    parameter int ACC_W = 24
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             mult_start,
    output logic [W-1:0]     mult_a,
    output logic [W-1:0]     mult_b,
    input  logic             mult_ready,
    input  logic [2*W-1:0]   mult_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_product,
    output logic             busy
`ifdef MJD_ACCUMULATE_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_sum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       mem_a_q [DEPTH];
    logic [W-1:0]       mem_a_d [DEPTH];
    logic [W-1:0]       mem_b_q [DEPTH];
    logic [W-1:0]       mem_b_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [W-1:0]       mult_a_q, mult_a_d;
    logic [W-1:0]       mult_b_q, mult_b_d;
    logic               out_valid_q, out_valid_d;
    logic [2*W-1:0]     out_product_q, out_product_d;

    logic               push;
    logic               pop;
    logic               capture;
    logic               deliver;
    logic               fifo_empty;

    // in_ready comes from the registered count only, so a pop while full does not free a slot until next cycle
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign capture    = (state_q == ST_WAIT_HIGH) && mult_ready;
    assign deliver    = out_valid_q && out_ready;

    assign mult_a      = mult_a_q;
    assign mult_b      = mult_b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;

    // State register and all datapath flops, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            mult_a_q      <= '0;
            mult_b_q      <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mult_a_q      <= mult_a_d;
            mult_b_q      <= mult_b_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= mem_a_d[i];
                mem_b_q[i] <= mem_b_d[i];
            end
        end
    end

    // Next-state logic; a pop is only issued from IDLE when the multiplier reports idle
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && mult_ready) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START:     state_d = ST_WAIT_LOW;
            ST_WAIT_LOW:  if (!mult_ready) state_d = ST_WAIT_HIGH;
            ST_WAIT_HIGH: if (mult_ready) state_d = ST_DRAIN;
            ST_DRAIN:     if (deliver) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; start lasts exactly one cycle because START always advances
    always_comb begin
        mult_start = (state_q == ST_START);
        busy       = (state_q != ST_IDLE) || !fifo_empty;
    end

    // FIFO storage, pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a_d[i] = mem_a_q[i];
            mem_b_d[i] = mem_b_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_a_d[wr_ptr_q] = in_a;
            mem_b_d[wr_ptr_q] = in_b;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Operand hold registers (change only on pop) and the product output register
    always_comb begin
        mult_a_d      = mult_a_q;
        mult_b_d      = mult_b_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        if (pop) begin
            mult_a_d = mem_a_q[rd_ptr_q];
            mult_b_d = mem_b_q[rd_ptr_q];
        end
        if (capture) begin
            out_valid_d   = 1'b1;
            out_product_d = mult_product;
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MJD_ACCUMULATE_EN
    logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
    logic [ACC_W-1:0] delivered_ext;

    assign delivered_ext = ACC_W'(out_product_q);
    assign acc_sum       = acc_sum_q;

    // Running sum of delivered products; a clear coinciding with a delivery restarts at that product
    always_comb begin
        acc_sum_d = acc_sum_q;
        if (acc_clr && deliver) begin
            acc_sum_d = delivered_ext;
        end else if (acc_clr) begin
            acc_sum_d = '0;
        end else if (deliver) begin
            acc_sum_d = acc_sum_q + delivered_ext;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sum_q <= '0;
        end else begin
            acc_sum_q <= acc_sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_mult_job_dispatcher.sv
// Bench for mult_job_dispatcher. It includes a simple multiplier model: ready falls the
// cycle after start and rises again after a random delay. Expected products come from a
// queue of a*b values, filled in acceptance order.
module tb_mult_job_dispatcher;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_a = '0;
    logic [W-1:0]     in_b = '0;
    logic             mult_start;
    logic [W-1:0]     mult_a;
    logic [W-1:0]     mult_b;
    logic             mult_ready;
    logic [2*W-1:0]   mult_product;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   out_product;
    logic             busy;
`ifdef MJD_ACCUMULATE_EN
    logic             acc_clr = 1'b0;
    logic [ACC_W-1:0] acc_sum;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W-1:0] exp_q[$];
    int lat_min = 0;
    int lat_max = 4;

    always #5 clk = ~clk;

    mult_job_dispatcher #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_ready(mult_ready), .mult_product(mult_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
        .busy(busy)
`ifdef MJD_ACCUMULATE_EN
        , .acc_clr(acc_clr), .acc_sum(acc_sum)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Multiplier model: busy for 1 + random cycles after each start; product only trustworthy while ready
    logic           m_ready;
    int             m_cnt;
    logic [W-1:0]   m_a, m_b;
    logic [2*W-1:0] m_prod;
    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
            m_prod  <= '0;
            m_a     <= '0;
            m_b     <= '0;
        end else if (mult_start) begin
            m_ready <= 1'b0;
            m_cnt   <= $urandom_range(lat_max, lat_min);
            m_a     <= mult_a;
            m_b     <= mult_b;
            m_prod  <= (2*W)'(mult_a) * (2*W)'(mult_b);
        end else if (!m_ready) begin
            if (m_cnt == 0) m_ready <= 1'b1;
            else m_cnt <= m_cnt - 1;
        end
    end
    assign mult_ready   = m_ready;
    assign mult_product = m_ready ? m_prod : ~m_prod;

    // Monitor: delivery order, output hold while stalled, single-cycle start, stable operands
    logic           prev_hold = 1'b0;
    logic           prev_rst = 1'b1;
    logic           prev_start = 1'b0;
    logic [2*W-1:0] prev_prod = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() == 0) check("no_stale_valid", 64'(out_valid), 64'd0);
            else if (out_valid && out_ready) check("deliver_order", 64'(out_product), 64'(exp_q.pop_front()));
            if (prev_hold && !prev_rst) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_product", 64'(out_product), 64'(prev_prod));
            end
            if (prev_start && !prev_rst) check("start_one_cycle", 64'(mult_start), 64'd0);
            if (!m_ready) check("operands_stable", 64'({mult_a, mult_b}), 64'({m_a, m_b}));
        end
        prev_hold  = out_valid && !out_ready;
        prev_prod  = out_product;
        prev_rst   = rst;
        prev_start = mult_start;
    end

`ifdef MJD_ACCUMULATE_EN
    // Accumulator reference: sum of delivered products, cleared by acc_clr
    logic [ACC_W-1:0] acc_model = '0;
    always @(negedge clk) begin
        check("acc_sum_track", 64'(acc_sum), 64'(acc_model));
        if (rst) acc_model = '0;
        else if (acc_clr && out_valid && out_ready) acc_model = ACC_W'(out_product);
        else if (acc_clr) acc_model = '0;
        else if (out_valid && out_ready) acc_model = acc_model + ACC_W'(out_product);
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (in_ready) exp_q.push_back((2*W)'(a) * (2*W)'(b));
        else check("push_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("out_valid_seen", 64'(out_valid), 64'd1);
        tick();
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy || out_valid) && t < 3000) begin
            t++;
            @(negedge clk);
        end
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        int accepted;
        int t;
        // Reset for two cycles, then check the first cycle after reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_mult_start", 64'(mult_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_product", 64'(out_product), 64'd0);
        check("rst_mult_ab", 64'({mult_a, mult_b}), 64'd0);

        // 3*5 held while out_ready is low
        out_ready = 1'b0;
        push(8'd3, 8'd5);
        wait_out_valid();
        check("p15_value", 64'(out_product), 64'd15);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("p15_held_valid", 64'(out_valid), 64'd1);
            check("p15_held_value", 64'(out_product), 64'd15);
        end
        tick();
        drain();

        // Extremes: 255*255 and a zero operand
        push(8'd255, 8'd255);
        push(8'd0, 8'd200);
        out_ready = 1'b0;
        wait_out_valid();
        check("p_fe01", 64'(out_product), 64'hFE01);
        drain();
        check("p_zero", 64'(out_product), 64'd0);

        // Continuous pushes with consumer stalled: DEPTH in FIFO plus one in flight
        out_ready = 1'b0;
        accepted = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            @(negedge clk);
            if (in_ready) begin
                accepted++;
                exp_q.push_back((2*W)'(in_a) * (2*W)'(in_b));
            end
            tick();
        end
        in_valid = 1'b0;
        check("burst_accepted", 64'(accepted), 64'(DEPTH + 1));
        check("burst_in_ready_low", 64'(in_ready), 64'd0);
        drain();

        // Reset while waiting for the multiplier to finish, with another job buffered
        lat_min = 8;
        lat_max = 8;
        out_ready = 1'b1;
        push(8'd9, 8'd9);
        push(8'd2, 8'd2);
        t = 0;
        @(negedge clk);
        while (m_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        check("wait_ready_low", 64'(m_ready), 64'd0);
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_mult_start", 64'(mult_start), 64'd0);
        repeat (30) tick();
        check("midrst_quiet_busy", 64'(busy), 64'd0);
        lat_min = 0;
        lat_max = 4;

`ifdef MJD_ACCUMULATE_EN
        // Accumulator: 15 + FE01 = 00FE10, then clear coinciding with delivery of 7
        push(8'd3, 8'd5);
        push(8'd255, 8'd255);
        drain();
        check("acc_fe10", 64'(acc_sum), 64'h00FE10);
        out_ready = 1'b0;
        push(8'd7, 8'd1);
        wait_out_valid();
        out_ready = 1'b1;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        check("acc_clr_with_delivery", 64'(acc_sum), 64'd7);
        drain();
`endif

        // Random traffic: random offers, random back-pressure
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_a = W'($urandom);
            in_b = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef MJD_ACCUMULATE_EN
            acc_clr = ($urandom_range(0, 15) == 0);
`endif
            @(negedge clk);
            if (in_valid && in_ready) exp_q.push_back((2*W)'(in_a) * (2*W)'(in_b));
            tick();
        end
        in_valid = 1'b0;
`ifdef MJD_ACCUMULATE_EN
        acc_clr = 1'b0;
`endif
        drain();

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
